// File: rtl/dm_arbiter_if.sv
// Requester and data-memory bus bundle for the CPU/DMA data-memory arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dm_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        cpu_err;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [3:0]  dma_be;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        dma_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_be,
    output dma_gnt, dma_rvalid, dma_rdata, dma_err,
    output mem_addr, mem_wdata, mem_be, mem_we,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_be,
    input  dma_gnt, dma_rvalid, dma_rdata, dma_err,
    input  mem_addr, mem_wdata, mem_be, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter between CPU and DMA: CPU priority with a
// bounded streak so DMA is guaranteed a slot, one-cycle registered responses.
module dm_arbiter #(
  parameter int STREAK_MAX = 4,
  parameter int DM_WORDS   = 4096
) (
  input  logic         Clk,
  input  logic         Reset,
  dm_arbiter_if.slave  bus
);

  localparam int              SW         = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0]   STREAK_TOP = SW'(STREAK_MAX);
  localparam logic [31:0]     WORD_LIMIT = 32'(DM_WORDS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CPU  = 2'd1;
  localparam logic [1:0] ST_DMA  = 2'd2;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == STREAK_TOP) ? v : v + SW'(1);
  endfunction

  function automatic logic in_range(input logic [31:0] a);
    return (a >> 2) < WORD_LIMIT;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;
  logic [31:0]   dma_rdata_q, dma_rdata_d;
  logic          cpu_err_q, cpu_err_d;
  logic          dma_err_q, dma_err_d;

  logic          cpu_gnt, dma_gnt, any_gnt;
  logic          cpu_ok, dma_ok, sel_ok, sel_we;
  logic [31:0]   sel_addr, sel_wdata, resp_data;
  logic [3:0]    sel_be;

  // Grant: CPU wins contention unless it has already taken STREAK_MAX in a row.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!Reset) begin
      cpu_gnt = bus.cpu_req && (!bus.dma_req || (streak_q != STREAK_TOP));
      dma_gnt = bus.dma_req && (!bus.cpu_req || (streak_q == STREAK_TOP));
    end
  end

  assign any_gnt = cpu_gnt || dma_gnt;
  assign cpu_ok  = in_range(bus.cpu_addr);
  assign dma_ok  = in_range(bus.dma_addr);

  always_comb begin
    sel_addr  = 32'd0;
    sel_wdata = 32'd0;
    sel_be    = 4'd0;
    sel_we    = 1'b0;
    sel_ok    = 1'b0;
    if (cpu_gnt) begin
      sel_addr  = bus.cpu_addr;
      sel_wdata = bus.cpu_wdata;
      sel_be    = bus.cpu_be;
      sel_we    = bus.cpu_we;
      sel_ok    = cpu_ok;
    end else if (dma_gnt) begin
      sel_addr  = bus.dma_addr;
      sel_wdata = bus.dma_wdata;
      sel_be    = bus.dma_be;
      sel_we    = bus.dma_we;
      sel_ok    = dma_ok;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.dma_gnt   = dma_gnt;
  assign bus.mem_addr  = sel_addr & ~32'h3;
  assign bus.mem_wdata = sel_wdata;
  assign bus.mem_be    = sel_be;
  assign bus.mem_we    = any_gnt && sel_we && sel_ok && (sel_be != 4'd0);

  // Writes and out-of-range accesses answer with zero data.
  assign resp_data = (sel_we || !sel_ok) ? 32'd0 : (bus.mem_rdata & lane_mask(sel_be));

  always_comb begin
    state_d = ST_IDLE;
    if (cpu_gnt)      state_d = ST_CPU;
    else if (dma_gnt) state_d = ST_DMA;

    streak_d = streak_q;
    if (!bus.dma_req || dma_gnt) streak_d = '0;
    else if (cpu_gnt)            streak_d = sat_inc(streak_q);

    cpu_rdata_d = cpu_gnt ? resp_data : cpu_rdata_q;
    cpu_err_d   = cpu_gnt ? !cpu_ok   : cpu_err_q;
    dma_rdata_d = dma_gnt ? resp_data : dma_rdata_q;
    dma_err_d   = dma_gnt ? !dma_ok   : dma_err_q;
  end

  // Response stage: owner state selects which port's rvalid fires.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      cpu_rdata_q <= 32'd0;
      dma_rdata_q <= 32'd0;
      cpu_err_q   <= 1'b0;
      dma_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_err_q   <= cpu_err_d;
      dma_err_q   <= dma_err_d;
    end
  end

  assign bus.cpu_rvalid = (state_q == ST_CPU);
  assign bus.dma_rvalid = (state_q == ST_DMA);
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.cpu_err    = cpu_err_q;
  assign bus.dma_err    = dma_err_q;

endmodule
